// File: rtl/instr_receive_buffer.sv
`default_nettype none
// ============================================================================
// Module : instr_receive_buffer
// Requests instruction words from the transmitter and queues them in a
// show-ahead FIFO for the decode stage. RECV_ACK_TIMEOUT_EN adds an ack watchdog.
// Rev    : 1.0
// ============================================================================
module instr_receive_buffer #(
  parameter int IWIDTH    = 32,
  parameter int FDEPTH    = 4,
  parameter int NUM_INSTR = 36,
  parameter int TIMEOUT   = 8
) (
  input  logic                         t_clk,
  input  logic                         t_rst,
  input  logic                         r_i_en,
  input  logic                         r_i_flush,
  output logic                         r_o_syn,
  input  logic [IWIDTH-1:0]            r_i_instr,
  input  logic                         r_i_ack,
  output logic [IWIDTH-1:0]            r_o_instr,
  output logic                         r_o_valid,
  input  logic                         r_i_ready,
  output logic [$clog2(NUM_INSTR)-1:0] r_o_idx,
  output logic [$clog2(FDEPTH):0]      r_o_count,
  output logic                         r_o_err
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam int XW = $clog2(NUM_INSTR);
  localparam int SW = PW + 2;
  localparam int AW = ((XW > SW) ? XW : SW) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              syn_q, syn_d;
  logic              err_q, err_d;
  logic [XW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [IWIDTH-1:0] mem_q [FDEPTH];
  logic [IWIDTH-1:0] mem_d [FDEPTH];

  logic          discard;
  logic          ack_ok;
  logic          full;
  logic          push;
  logic          pop;
  logic          tmo_expire;
  logic [SW-1:0] demand;
  logic [AW-1:0] idx_sum;

`ifdef RECV_ACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          miss;

  // A missing ack is any cycle where syn_q expects data that does not arrive.
  always_comb begin
    miss  = syn_q && !r_i_ack && !r_i_flush &&
            ((state_q == S_RUN) || (state_q == S_WAIT));
    tmo_d = tmo_q;
    if (r_i_ack || r_i_flush) begin
      tmo_d = '0;
    end else if (miss) begin
      tmo_d = (tmo_q == TW'(TIMEOUT - 1)) ? '0 : tmo_q + TW'(1);
    end
  end

  assign tmo_expire = miss && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    syn_d   = req_q;
    err_d   = err_q;
    idx_d   = idx_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;

    discard = r_i_flush || (state_q == S_FLUSH);
    ack_ok  = r_i_ack && syn_q && !discard;
    full    = (count_q == CW'(FDEPTH));
    push    = ack_ok && !full;
    pop     = (count_q != '0) && r_i_ready && !r_i_flush;
    demand  = SW'(count_q) + SW'(syn_q) + SW'(req_q);

    // Flushed words still consumed transmitter indices, so skip past them.
    idx_sum = AW'(idx_q) + AW'(count_q) + AW'(syn_q) + AW'(req_q);
    if (idx_sum >= AW'(NUM_INSTR)) begin
      idx_sum = idx_sum - AW'(NUM_INSTR);
    end

    if ((r_i_ack && !syn_q && !discard) || (ack_ok && full)) begin
      err_d = 1'b1;
    end

    if (r_i_flush) begin
      state_d = S_FLUSH;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      idx_d   = idx_sum[XW-1:0];
    end else begin
      if (push) begin
        mem_d[wptr_q] = r_i_instr;
        wptr_d        = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
        idx_d  = (idx_q == XW'(NUM_INSTR - 1)) ? '0 : idx_q + XW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end

      case (state_q)
        S_IDLE:  if (r_i_en) state_d = S_RUN;
        S_RUN: begin
          if (!r_i_en) begin
            state_d = S_WAIT;
          end else begin
            req_d = (demand < SW'(FDEPTH));
          end
        end
        S_WAIT:  if (!syn_q) state_d = S_IDLE;
        S_FLUSH: state_d = r_i_en ? S_RUN : S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (tmo_expire) begin
        err_d   = 1'b1;
        req_d   = 1'b0;
        syn_d   = 1'b0;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      syn_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      syn_q   <= syn_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
    end
  end

  assign r_o_syn   = req_q;
  assign r_o_valid = (count_q != '0);
  assign r_o_instr = mem_q[rptr_q];
  assign r_o_idx   = idx_q;
  assign r_o_count = count_q;
  assign r_o_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_receive_buffer.sv
`default_nettype none
// Directed bench for instr_receive_buffer with a one-cycle transmitter model.
module tb_instr_receive_buffer;

  localparam int IWIDTH    = 32;
  localparam int FDEPTH    = 4;
  localparam int NUM_INSTR = 36;

  logic        t_clk = 1'b0;
  logic        t_rst = 1'b1;
  logic        r_i_en;
  logic        r_i_flush;
  logic        r_o_syn;
  logic [31:0] r_i_instr;
  logic        r_i_ack;
  logic [31:0] r_o_instr;
  logic        r_o_valid;
  logic        r_i_ready;
  logic [5:0]  r_o_idx;
  logic [2:0]  r_o_count;
  logic        r_o_err;

  logic        tx_ack;
  logic [31:0] tx_data;
  int          tx_cnt;
  logic        inject;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_idx;
  int w;

  always #5 t_clk = ~t_clk;

  instr_receive_buffer #(
    .IWIDTH   (IWIDTH),
    .FDEPTH   (FDEPTH),
    .NUM_INSTR(NUM_INSTR),
    .TIMEOUT  (8)
  ) dut (
    .t_clk    (t_clk),
    .t_rst    (t_rst),
    .r_i_en   (r_i_en),
    .r_i_flush(r_i_flush),
    .r_o_syn  (r_o_syn),
    .r_i_instr(r_i_instr),
    .r_i_ack  (r_i_ack),
    .r_o_instr(r_o_instr),
    .r_o_valid(r_o_valid),
    .r_i_ready(r_i_ready),
    .r_o_idx  (r_o_idx),
    .r_o_count(r_o_count),
    .r_o_err  (r_o_err)
  );

  function automatic logic [31:0] word(input int i);
    return 32'h0000_0013 ^ (32'(i) * 32'h0050_0080);
  endfunction

  // Transmitter: a request seen at an edge returns data one cycle later.
  always @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      tx_ack  <= 1'b0;
      tx_data <= 32'h0;
      tx_cnt  <= 0;
    end else begin
      tx_ack <= r_o_syn;
      if (r_o_syn) begin
        tx_data <= word(tx_cnt);
        tx_cnt  <= (tx_cnt == NUM_INSTR - 1) ? 0 : tx_cnt + 1;
      end
    end
  end

  assign r_i_ack   = tx_ack | inject;
  assign r_i_instr = inject ? 32'hDEAD_BEEF : tx_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  initial begin
    r_i_en    = 1'b0;
    r_i_ready = 1'b0;
    r_i_flush = 1'b0;
    inject    = 1'b0;

    #1 t_rst = 1'b0;
    #1;
    chk("rst_syn",   64'(r_o_syn),   64'(0));
    chk("rst_valid", 64'(r_o_valid), 64'(0));
    chk("rst_instr", 64'(r_o_instr), 64'(0));
    chk("rst_idx",   64'(r_o_idx),   64'(0));
    chk("rst_count", 64'(r_o_count), 64'(0));
    chk("rst_err",   64'(r_o_err),   64'(0));
    tick();
    tick();
    t_rst = 1'b1;
    tick();

    // Basic stream
    r_i_en    = 1'b1;
    r_i_ready = 1'b1;
    tick();
    chk("run_syn0", 64'(r_o_syn), 64'(0));
    tick();
    chk("first_syn",   64'(r_o_syn),   64'(1));
    chk("first_valid0", 64'(r_o_valid), 64'(0));
    tick();
    chk("first_valid1", 64'(r_o_valid), 64'(0));
    tick();
    chk("first_valid2", 64'(r_o_valid), 64'(1));
    chk("word0",        64'(r_o_instr), 64'(32'h0000_0013));
    chk("idx0",         64'(r_o_idx),   64'(0));
    tick();
    chk("word1", 64'(r_o_instr), 64'(32'h0050_0093));
    chk("idx1",  64'(r_o_idx),   64'(1));
    tick();
    chk("idx2",    64'(r_o_idx),   64'(2));
    chk("count_1", 64'(r_o_count), 64'(1));
    exp_idx = 2;

    // Backpressure
    r_i_ready = 1'b0;
    repeat (3) tick();
    chk("bp_count", 64'(r_o_count), 64'(4));
    chk("bp_syn",   64'(r_o_syn),   64'(0));
    chk("bp_err",   64'(r_o_err),   64'(0));
    chk("bp_idx",   64'(r_o_idx),   64'(2));
    repeat (3) tick();
    chk("bp_hold_count", 64'(r_o_count), 64'(4));
    chk("bp_hold_syn",   64'(r_o_syn),   64'(0));
    chk("bp_head",       64'(r_o_instr), 64'(word(2)));

    // Resume and run through the index wrap
    r_i_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      chk("str_valid", 64'(r_o_valid), 64'(1));
      chk("str_instr", 64'(r_o_instr), 64'(word(exp_idx)));
      chk("str_idx",   64'(r_o_idx),   64'(exp_idx));
      if (k > 30 && exp_idx == 0) begin
        chk("wrap_word0", 64'(r_o_instr), 64'(32'h0000_0013));
      end
      tick();
      exp_idx = (exp_idx + 1) % NUM_INSTR;
    end
    chk("steady_count", 64'(r_o_count), 64'(1));

    // Flush with two buffered words and one in flight
    r_i_en    = 1'b0;
    r_i_ready = 1'b0;
    tick();
    chk("pre_flush_count", 64'(r_o_count), 64'(2));
    chk("pre_flush_idx",   64'(r_o_idx),   64'(exp_idx));
    r_i_flush = 1'b1;
    r_i_en    = 1'b1;
    tick();
    r_i_flush = 1'b0;
    exp_idx   = (exp_idx + 3) % NUM_INSTR;
    chk("flush_count", 64'(r_o_count), 64'(0));
    chk("flush_valid", 64'(r_o_valid), 64'(0));
    chk("flush_idx",   64'(r_o_idx),   64'(exp_idx));
    chk("flush_err",   64'(r_o_err),   64'(0));
    chk("flush_syn",   64'(r_o_syn),   64'(0));
    tick();
    chk("flush_win_err", 64'(r_o_err), 64'(0));
    r_i_ready = 1'b1;
    w = 0;
    while (!r_o_valid && w < 12) begin
      tick();
      w++;
    end
    chk("resume_valid", 64'(r_o_valid), 64'(1));
    for (int k = 0; k < 4; k++) begin
      chk("resume_instr", 64'(r_o_instr), 64'(word(exp_idx)));
      chk("resume_idx",   64'(r_o_idx),   64'(exp_idx));
      tick();
      exp_idx = (exp_idx + 1) % NUM_INSTR;
    end

    // Protocol error from an unrequested ack
    r_i_en = 1'b0;
    repeat (8) tick();
    chk("drain_count", 64'(r_o_count), 64'(0));
    chk("drain_syn",   64'(r_o_syn),   64'(0));
    chk("drain_err",   64'(r_o_err),   64'(0));
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("perr_err",   64'(r_o_err),   64'(1));
    chk("perr_count", 64'(r_o_count), 64'(0));
    repeat (5) tick();
    chk("perr_sticky", 64'(r_o_err), 64'(1));

    // Asynchronous reset with three words buffered
    r_i_en    = 1'b1;
    r_i_ready = 1'b0;
    w = 0;
    while (r_o_count != 3'd3 && w < 20) begin
      tick();
      w++;
    end
    chk("pre_rst_count", 64'(r_o_count), 64'(3));
    t_rst = 1'b0;
    #1;
    chk("arst_syn",   64'(r_o_syn),   64'(0));
    chk("arst_valid", 64'(r_o_valid), 64'(0));
    chk("arst_instr", 64'(r_o_instr), 64'(0));
    chk("arst_idx",   64'(r_o_idx),   64'(0));
    chk("arst_count", 64'(r_o_count), 64'(0));
    chk("arst_err",   64'(r_o_err),   64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
